// File: rtl/arb_pkg.sv
// arb_pkg: shared constants for the dual-core bus arbiter (core indices, burst default, widths).
package arb_pkg;
  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;
  localparam int DEF_MAX_BURST = 4;
  localparam int BYTE_W = 8;
  localparam int CNT_W = 4;
endpackage

// File: rtl/arb_stats_counter.sv
// arb_stats_counter: wrapping W-bit event counter (clk, reset, i_en -> o_count); only built with ARB_STATS_EN.
`ifdef ARB_STATS_EN
module arb_stats_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk) r_count <= reset ? '0 : r_count + W'(i_en);
  assign o_count = r_count;
endmodule
`endif

// File: rtl/dual_core_bus_arbiter.sv
// dual_core_bus_arbiter: round-robin byte-memory arbiter for two cores with burst ownership.
// Ports: clk/reset (sync, active-high); per core reqN/weN/addrN/wdataN in, grantN out;
// memory side mem_addr/mem_wdata/mem_we/mem_re out, mem_rdata in, rdata broadcast back.
// ARB_STATS_EN adds gcount0/gcount1 (granted cycles) and wait0/wait1 (stalled request cycles).
module dual_core_bus_arbiter
  import arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ARB_STATS_EN
  output logic [31:0]       gcount0,
  output logic [31:0]       gcount1,
  output logic [31:0]       wait0,
  output logic [31:0]       wait1,
`endif
  input  logic              req0,
  input  logic              we0,
  input  logic [AW-1:0]     addr0,
  input  logic [BYTE_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AW-1:0]     addr1,
  input  logic [BYTE_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic [BYTE_W-1:0] rdata,
  output logic [AW-1:0]     mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [BYTE_W-1:0] mem_rdata
);
  localparam logic [CNT_W-1:0] MB = CNT_W'(MAX_BURST);
  logic             r_owner_vld, r_owner, r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             w_own_keep, w_win_vld, w_win, w_win_we;
  // The owner keeps the bus only while still requesting and within its burst budget;
  // otherwise contention alternates away from the last granted core.
  always_comb begin
    w_own_keep = r_owner_vld && (r_owner == CORE1 ? req1 : req0) && (r_cnt < MB);
    w_win_vld  = !reset && (req0 || req1);
    w_win      = w_own_keep ? r_owner : (req0 && req1) ? ~r_last : (req1 ? CORE1 : CORE0);
    w_win_we   = (w_win == CORE1) ? we1 : we0;
  end
  assign grant0    = w_win_vld && (w_win == CORE0);
  assign grant1    = w_win_vld && (w_win == CORE1);
  assign mem_addr  = !w_win_vld ? '0 : (w_win == CORE1) ? addr1 : addr0;
  assign mem_wdata = !w_win_vld ? '0 : (w_win == CORE1) ? wdata1 : wdata0;
  assign mem_we    = w_win_vld && w_win_we;
  assign mem_re    = w_win_vld && !w_win_we;
  assign rdata     = mem_rdata;
  // Losing the bus for any reason (including exhausting the burst) restarts the tenure count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner_vld <= 1'b0;
      r_owner     <= CORE0;
      r_last      <= CORE1;
      r_cnt       <= '0;
    end else if (w_win_vld) begin
      r_owner_vld <= 1'b1;
      r_owner     <= w_win;
      r_last      <= w_win;
      r_cnt       <= w_own_keep ? r_cnt + 1'b1 : CNT_W'(1);
    end else begin
      r_owner_vld <= 1'b0;
      r_cnt       <= '0;
    end
  end
`ifdef ARB_STATS_EN
  arb_stats_counter #(.W(32)) u_gcount0 (.clk(clk), .reset(reset), .i_en(grant0),          .o_count(gcount0));
  arb_stats_counter #(.W(32)) u_gcount1 (.clk(clk), .reset(reset), .i_en(grant1),          .o_count(gcount1));
  arb_stats_counter #(.W(32)) u_wait0   (.clk(clk), .reset(reset), .i_en(req0 && !grant0), .o_count(wait0));
  arb_stats_counter #(.W(32)) u_wait1   (.clk(clk), .reset(reset), .i_en(req1 && !grant1), .o_count(wait1));
`endif
endmodule

// File: doc/dual_core_bus_arbiter.md
Name: dual_core_bus_arbiter

Overview:
- Shared-memory arbiter sitting directly upstream of each core's multicycle controller; generates the per-core `grant` that the controller waits on in FETCH1-4, LBRD and SBWR.
- Arbitrates byte-wide single-cycle memory accesses from two cores onto one synchronous-write / combinational-read memory port.
- Round-robin with burst ownership, so a core can finish a 4-byte instruction fetch uninterrupted.

Parameters:
- AW, 32, address width of each core request and of the memory port.
- MAX_BURST, 4, maximum consecutive grants one core keeps before fairness arbitration applies; range 1..15.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  core0 access request (core memread|memwrite).
- we0  input  1  core0 write strobe, meaningful only with req0.
- addr0  input  AW  core0 byte address.
- wdata0  input  8  core0 write byte.
- req1  input  1  core1 access request.
- we1  input  1  core1 write strobe.
- addr1  input  AW  core1 byte address.
- wdata1  input  8  core1 write byte.
- grant0  output  1  core0 access completes at the next posedge.
- grant1  output  1  core1 access completes at the next posedge.
- rdata  output  8  read byte, broadcast to both cores (= mem_rdata).
- mem_addr  output  AW  memory address (muxed from the winning core).
- mem_wdata  output  8  memory write byte (muxed from the winning core).
- mem_we  output  1  memory write enable.
- mem_re  output  1  memory read enable.
- mem_rdata  input  8  combinational read data from memory.

Behaviour:
- Registered state:
  - `owner_vld`, `owner` (1 bit): current bus owner.
  - `last` (1 bit): core most recently granted.
  - `cnt` (4 bits): grants in the current tenure.
- Reset: `owner_vld`=0, `owner`=0, `last`=1 (core0 wins the first contention), `cnt`=0.
- While reset is high:
  - grant0=grant1=0, mem_we=0, mem_re=0.
  - mem_addr=0, mem_wdata=0.
- Winner selection is combinational from current req and state, in priority order:
  1. `owner_vld` && req[owner] && `cnt` < MAX_BURST -> winner = owner.
  2. Else req0 && req1 -> winner = ~last.
  3. Else the sole requester.
  4. Else no winner.
- Zero-latency grant: grantN=1 in the same cycle reqN is high and N wins. At most one grant is high per cycle.
- Memory port:
  - mem_addr and mem_wdata come from the winner; mem_we = winner's we; mem_re = winner's req & ~we.
  - With no winner: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- Posedge update with a winner W:
  - `cnt` <= (`owner_vld` && `owner`==W && `cnt`<MAX_BURST) ? `cnt`+1 : 1.
  - `owner` <= W, `owner_vld` <= 1, `last` <= W.
- Posedge update with no winner: `owner_vld` <= 0, `cnt` <= 0; `last` is kept.
- Owner drops req: ownership is lost that same cycle. The other core is granted immediately if requesting; no idle bubble.
- Burst exhausted (`cnt`==MAX_BURST):
  - Other core requesting -> other core wins.
  - Other core idle -> owner re-wins and `cnt` restarts at 1.
- Requests are level-held by cores until granted. The arbiter never latches addr/data; the transfer occurs entirely in the granted cycle.
- Simultaneous first requests from IDLE after reset -> core0 wins.
- Reset mid-burst: state clears at the next posedge and grants are suppressed while reset is high. Cores are reset together and restart at FETCH1.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs `gcount0`, `gcount1` (32-bit each): number of granted cycles per core.
  - Adds outputs `wait0`, `wait1` (32-bit each): cycles with reqN=1 and grantN=0.
  - All four counters are cleared by reset and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `arb_pkg`:
  - Core index constants CORE0=1'b0, CORE1=1'b1.
  - Default MAX_BURST value.
  - Width constant BYTE_W=8.
- One natural sub-module: `arb_stats_counter` (saturating-free 32-bit counter with enable and sync reset), instantiated four times under ARB_STATS_EN.

Test Plan:
- Reset, then req0=1 only, addr0=0x10 held 4 cycles:
  - grant0=1 in cycles 1-4, grant1=0 throughout.
  - mem_re=1, mem_addr=0x10.
- req0 and req1 both rise the same cycle after reset, both held:
  - grant0 for 4 cycles, then grant1 for 4 cycles, then grant0.
  - grant0 and grant1 are never both high.
- Core0 holds req for 6 cycles while core1 is idle:
  - grant0 continuous for all 6 cycles.
  - `cnt` sequence 1,2,3,4,1,2.
- Core1 owns with `cnt`=2, drops req1 while req0=1:
  - grant0=1 in that same cycle.
- req1=1, we1=1, addr1=0x3C, wdata1=0xA5:
  - mem_we=1, mem_addr=0x3C, mem_wdata=0xA5, mem_re=0 in the grant cycle.
  - Memory byte 0x3C reads back 0xA5.
- Reset asserted during a core0 burst at `cnt`=2, req0 held:
  - grants 0 while reset is high.
  - After release, grant0 resumes with `cnt`=1.
  - With ARB_STATS_EN, all counters read 0 after reset.
